hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core, companion to the EX-stage forwarding unit. It covers the hazards forwarding cannot resolve: load-use dependencies, taken-branch flushes resolved in EX, and multi-cycle data-memory waits. It drives PC/IF_ID write enables, ID_EX bubble/flush, IF_ID flush and the EX_MEM/MEM_WB hold. It also keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

---
 rtl/core_ctrl_pkg.sv | 27 ++
 rtl/hazard_stall_ctrl_sat_counter.sv | 20 ++
 rtl/hazard_stall_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the hazard controller and the EX forwarding unit.
package core_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load in EX whose rd feeds a source of the ID instruction; x0 is never a dependency.
  function automatic logic load_use_hit(
    input logic       ex_memread,
    input logic [4:0] ex_rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return ex_memread && (ex_rd != REG_ZERO) &&
           ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, holds at all-ones.
// Synchronous active-low reset to zero.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use stalls, taken-branch flushes and data-memory wait freezes.
// Control outputs are combinational from state and inputs; counters and timeout are registered.
module hazard_stall_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64,
  parameter int TW_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [TW_W-1:0] MAX_WAIT_C = TW_W'(MAX_WAIT);

  ctrl_state_t     state;
  logic [TW_W-1:0] wait_cnt;
  logic [TW_W-1:0] wait_nxt;
  logic            load_use;
  logic            freeze;

  assign load_use = load_use_hit(id_ex_memread, id_ex_rd, id_rs1, id_rs2, id_uses_rs2);

  // The cycle that starts a wait is already frozen, as is the ready cycle ending it.
  assign freeze = (state == MEM_WAIT) || (mem_req && !mem_ready);

  assign wait_nxt = (wait_cnt == {TW_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_hold    = 1'b0;
    if (freeze) begin
      // A taken branch stays parked in EX and flushes once the freeze lifts.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (mem_req && !mem_ready) begin
            state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == MAX_WAIT_C) begin
              mem_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a short MAX_WAIT so timeouts are reachable.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, id_ex_rd;
  logic             id_uses_rs2, id_ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic             pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush;
  logic             pipe_hold, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(4), .TW_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs2     (id_uses_rs2),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rd        (id_ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .pipe_hold       (pipe_hold),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0; id_uses_rs2 = 0; id_ex_memread = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Advance one edge, then let the new inputs settle before mid-cycle sampling.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pc_write", pc_write, 1);
    check("rst_if_id_write", if_id_write, 1);
    check("rst_bubble", id_ex_bubble, 0);
    check("rst_flush", {if_id_flush, id_ex_flush}, 0);
    check("rst_hold", pipe_hold, 0);
    check("rst_timeout", mem_timeout, 0);
    check("rst_stall_cnt", stall_count, 0);
    check("rst_flush_cnt", flush_count, 0);

    // load-use on rs1
    next_cycle();
    id_ex_memread = 1; id_ex_rd = 5; id_rs1 = 5;
    @(negedge clk);
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_bubble", id_ex_bubble, 1);
    next_cycle(); clear_inputs();
    @(negedge clk);
    check("lu_stall_cnt", stall_count, 1);
    check("lu_after_pc_write", pc_write, 1);

    // rs2 match ignored unless rs2 is read
    next_cycle();
    id_ex_memread = 1; id_ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 0; id_rs1 = 3;
    @(negedge clk);
    check("rs2_gated_pc_write", pc_write, 1);
    check("rs2_gated_bubble", id_ex_bubble, 0);
    next_cycle(); id_uses_rs2 = 1;
    @(negedge clk);
    check("rs2_used_bubble", id_ex_bubble, 1);
    next_cycle(); clear_inputs();
    id_ex_memread = 1; id_ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    check("x0_pc_write", pc_write, 1);
    check("x0_stall_cnt", stall_count, 2);

    // branch beats load-use
    next_cycle(); clear_inputs();
    ex_branch_taken = 1; id_ex_memread = 1; id_ex_rd = 5; id_rs1 = 5;
    @(negedge clk);
    check("br_if_id_flush", if_id_flush, 1);
    check("br_id_ex_flush", id_ex_flush, 1);
    check("br_pc_write", pc_write, 1);
    check("br_bubble", id_ex_bubble, 0);
    next_cycle(); clear_inputs();
    @(negedge clk);
    check("br_flush_cnt", flush_count, 1);
    check("br_stall_cnt", stall_count, 2);

    // three wait cycles then ready: four frozen cycles
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      mem_req = 1; mem_ready = (i == 3);
      @(negedge clk);
      check($sformatf("mw_hold_%0d", i), pipe_hold, 1);
      check($sformatf("mw_pc_write_%0d", i), pc_write, 0);
    end
    next_cycle(); clear_inputs();
    @(negedge clk);
    check("mw_back_run_hold", pipe_hold, 0);
    check("mw_back_run_pc_write", pc_write, 1);
    check("mw_stall_cnt", stall_count, 6);
    check("mw_timeout", mem_timeout, 0);

    // ready withheld 10 cycles with a taken branch parked in EX
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      ex_branch_taken = 1; mem_req = 1; mem_ready = (i == 10);
      @(negedge clk);
      check($sformatf("to_no_flush_%0d", i), if_id_flush, 0);
      check($sformatf("to_timeout_%0d", i), mem_timeout, (i >= 5) ? 1 : 0);
    end
    next_cycle();
    mem_req = 0; mem_ready = 0; ex_branch_taken = 1;
    @(negedge clk);
    check("to_late_flush", if_id_flush, 1);
    check("to_late_pc_write", pc_write, 1);
    next_cycle(); clear_inputs();
    @(negedge clk);
    check("to_single_flush", if_id_flush, 0);
    check("to_flush_cnt", flush_count, 2);
    check("to_stall_cnt", stall_count, 17);
    check("to_sticky", mem_timeout, 1);

    // reset in the middle of a wait
    next_cycle(); mem_req = 1; mem_ready = 0;
    next_cycle(); rst_n = 0;
    @(negedge clk);
    check("rmw_frozen", pipe_hold, 1);
    next_cycle(); rst_n = 1; clear_inputs();
    @(negedge clk);
    check("rmw_pc_write", pc_write, 1);
    check("rmw_hold", pipe_hold, 0);
    check("rmw_stall_cnt", stall_count, 0);
    check("rmw_flush_cnt", flush_count, 0);
    check("rmw_timeout", mem_timeout, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
